// File: rtl/mem_stage_32.sv
// Memory stage of the 32-bit pipeline: forwards ALU results to writeback,
// runs LD/ST requests against the data memory, and pulses err on misaligned
// accesses or when a request outlives TIMEOUT cycles without an ack.
module mem_stage_32 #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_res,
  input  logic [31:0] in_st_data,
  input  logic [4:0]  in_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err
);

  localparam logic [3:0] OP_LD    = 4'hB;
  localparam logic [3:0] OP_ST    = 4'hC;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {IDLE, MEM_WAIT} state_t;

  state_t      state, state_nx;
  logic [7:0]  cnt, cnt_nx;
  logic [4:0]  rd_q, rd_nx;
  logic        mem_req_nx, mem_we_nx;
  logic [31:0] mem_addr_nx, mem_wdata_nx;
  logic        wb_valid_nx, wb_we_nx, err_nx;
  logic [4:0]  wb_rd_nx;
  logic [31:0] wb_data_nx;

  assign in_ready = (state == IDLE);

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    rd_nx        = rd_q;
    mem_req_nx   = mem_req;
    mem_we_nx    = mem_we;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    wb_valid_nx  = 1'b0;
    wb_we_nx     = 1'b0;
    wb_rd_nx     = wb_rd;
    wb_data_nx   = wb_data;
    err_nx       = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (in_op == OP_LD || in_op == OP_ST) begin
            if (in_res[1:0] != 2'b00) begin
              wb_valid_nx = 1'b1;
              wb_rd_nx    = in_rd;
              wb_data_nx  = in_res;
              err_nx      = 1'b1;
            end else begin
              mem_req_nx   = 1'b1;
              mem_we_nx    = (in_op == OP_ST);
              mem_addr_nx  = in_res;
              mem_wdata_nx = (in_op == OP_ST) ? in_st_data : '0;
              rd_nx        = in_rd;
              cnt_nx       = '0;
              state_nx     = MEM_WAIT;
            end
          end else begin
            wb_valid_nx = 1'b1;
            wb_rd_nx    = in_rd;
            wb_data_nx  = in_res;
            wb_we_nx    = (in_op >= 4'd1 && in_op <= 4'd9) && (in_rd != 5'd0);
          end
        end
      end
      MEM_WAIT: begin
        // Ack is checked first so it wins over a timeout on the same edge.
        if (mem_ack) begin
          mem_req_nx  = 1'b0;
          state_nx    = IDLE;
          wb_valid_nx = 1'b1;
          wb_rd_nx    = rd_q;
          if (mem_we) begin
            wb_data_nx = mem_addr;
          end else begin
            wb_data_nx = mem_rdata;
            wb_we_nx   = (rd_q != 5'd0);
          end
        end else if (cnt == CNT_LAST) begin
          mem_req_nx  = 1'b0;
          state_nx    = IDLE;
          wb_valid_nx = 1'b1;
          err_nx      = 1'b1;
          cnt_nx      = '0;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_q      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      rd_q      <= rd_nx;
      mem_req   <= mem_req_nx;
      mem_we    <= mem_we_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
      wb_valid  <= wb_valid_nx;
      wb_we     <= wb_we_nx;
      wb_rd     <= wb_rd_nx;
      wb_data   <= wb_data_nx;
      err       <= err_nx;
    end
  end

endmodule

// File: tb/tb_mem_stage_32.sv
// Directed and randomized bench for mem_stage_32 (TIMEOUT overridden to 4).
module tb_mem_stage_32;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_res;
  logic [31:0] in_st_data;
  logic [4:0]  in_rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  mem_stage_32 #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_res(in_res), .in_st_data(in_st_data), .in_rd(in_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Non-memory op: writeback one cycle later; register write only for ops 1..9 with rd != 0.
  task automatic do_alu(input logic [3:0] op, input logic [31:0] res, input logic [4:0] rd);
    logic exp_we;
    exp_we = (op >= 4'd1 && op <= 4'd9) && (rd != 5'd0);
    chk("alu.in_ready", 32'(in_ready), 1);
    in_valid = 1'b1; in_op = op; in_res = res; in_rd = rd;
    in_st_data = $urandom; mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    step();
    in_valid = 1'b0; mem_ack = 1'b0;
    chk("alu.wb_valid", 32'(wb_valid), 1);
    chk("alu.wb_we",    32'(wb_we), 32'(exp_we));
    chk("alu.wb_rd",    32'(wb_rd), 32'(rd));
    chk("alu.wb_data",  wb_data, res);
    chk("alu.err",      32'(err), 0);
    chk("alu.mem_req",  32'(mem_req), 0);
    chk("alu.in_ready", 32'(in_ready), 1);
  endtask

  // LD/ST: ackc is the number of cycles mem_req is seen high before ack is sampled;
  // ackc > TMO means the ack never arrives inside the timeout window.
  task automatic do_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [4:0] rd, input int unsigned ackc, input logic [31:0] rdata);
    logic        is_st;
    int unsigned n;
    is_st = (op == 4'hC);
    chk("mem.in_ready_pre", 32'(in_ready), 1);
    in_valid = 1'b1; in_op = op; in_res = addr; in_st_data = sdata; in_rd = rd;
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    step();
    in_valid = 1'b0; in_op = 4'($urandom); in_res = $urandom; mem_ack = 1'b0;
    if (addr[1:0] != 2'b00) begin
      chk("mis.wb_valid", 32'(wb_valid), 1);
      chk("mis.wb_we",    32'(wb_we), 0);
      chk("mis.err",      32'(err), 1);
      chk("mis.mem_req",  32'(mem_req), 0);
      chk("mis.in_ready", 32'(in_ready), 1);
      return;
    end
    n = (ackc <= TMO) ? ackc : TMO;
    for (int unsigned k = 1; k <= n; k++) begin
      chk("wait.mem_req",   32'(mem_req), 1);
      chk("wait.mem_we",    32'(mem_we), 32'(is_st));
      chk("wait.mem_addr",  mem_addr, addr);
      chk("wait.mem_wdata", mem_wdata, is_st ? sdata : 32'd0);
      chk("wait.in_ready",  32'(in_ready), 0);
      chk("wait.wb_valid",  32'(wb_valid), 0);
      chk("wait.err",       32'(err), 0);
      if (k == ackc) begin
        mem_ack = 1'b1; mem_rdata = rdata;
      end else begin
        mem_rdata = $urandom;
      end
      step();
      mem_ack = 1'b0;
    end
    chk("done.mem_req",  32'(mem_req), 0);
    chk("done.in_ready", 32'(in_ready), 1);
    chk("done.wb_valid", 32'(wb_valid), 1);
    if (ackc <= TMO) begin
      chk("ack.err",   32'(err), 0);
      chk("ack.wb_rd", 32'(wb_rd), 32'(rd));
      if (is_st) begin
        chk("st.wb_data", wb_data, addr);
        chk("st.wb_we",   32'(wb_we), 0);
      end else begin
        chk("ld.wb_data", wb_data, rdata);
        chk("ld.wb_we",   32'(wb_we), 32'(rd != 5'd0));
      end
    end else begin
      chk("tmo.err",   32'(err), 1);
      chk("tmo.wb_we", 32'(wb_we), 0);
    end
  endtask

  initial begin
    logic [31:0] r;
    logic [3:0]  op;
    rst = 1'b1; in_valid = 1'b1; in_op = 4'd1; in_res = 32'h1234; in_st_data = '0;
    in_rd = 5'd3; mem_rdata = '0; mem_ack = 1'b1;
    step();
    step();
    chk("rst.in_ready",  32'(in_ready), 1);
    chk("rst.mem_req",   32'(mem_req), 0);
    chk("rst.mem_we",    32'(mem_we), 0);
    chk("rst.mem_addr",  mem_addr, 0);
    chk("rst.mem_wdata", mem_wdata, 0);
    chk("rst.wb_valid",  32'(wb_valid), 0);
    chk("rst.wb_we",     32'(wb_we), 0);
    chk("rst.wb_rd",     32'(wb_rd), 0);
    chk("rst.wb_data",   wb_data, 0);
    chk("rst.err",       32'(err), 0);
    rst = 1'b0; in_valid = 1'b0; mem_ack = 1'b0;
    step();
    chk("idle.wb_valid", 32'(wb_valid), 0);

    // ADD, LD with 3-cycle wait, ST acked immediately, misaligned LD, ST timeout.
    do_alu(4'd1, 32'h0000_0007, 5'd3);
    do_mem(4'hB, 32'h0000_1000, 32'h0, 5'd5, 3, 32'hDEAD_BEEF);
    do_mem(4'hC, 32'h0000_0020, 32'h55, 5'd9, 1, 32'h0);
    do_mem(4'hB, 32'h0000_0002, 32'h0, 5'd4, 1, 32'h0);
    do_mem(4'hC, 32'h0000_0040, 32'h77, 5'd2, TMO + 1, 32'h0);
    // Ack on the same edge the timeout would fire.
    do_mem(4'hB, 32'h0000_0080, 32'h0, 5'd6, TMO, 32'hCAFE_F00D);
    // LD to r0 completes without a register write.
    do_mem(4'hB, 32'h0000_0100, 32'h0, 5'd0, 2, 32'h1111_2222);
    // Non-register ops and write to r0.
    do_alu(4'd0, 32'hAAAA_0000, 5'd7);
    do_alu(4'hA, 32'h0000_BBBB, 5'd7);
    do_alu(4'hF, 32'h0F0F_0F0F, 5'd8);
    do_alu(4'd9, 32'h8000_0001, 5'd0);

    // Reset while waiting: request dropped, no writeback, in_valid during reset ignored.
    in_valid = 1'b1; in_op = 4'hB; in_res = 32'h0000_0200; in_rd = 5'd11;
    step();
    in_valid = 1'b0;
    chk("rw.mem_req1", 32'(mem_req), 1);
    step();
    chk("rw.mem_req2", 32'(mem_req), 1);
    rst = 1'b1; in_valid = 1'b1; in_op = 4'd1; in_res = 32'h5; in_rd = 5'd1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("rw.mem_req",  32'(mem_req), 0);
    chk("rw.wb_valid", 32'(wb_valid), 0);
    chk("rw.in_ready", 32'(in_ready), 1);
    chk("rw.wb_data",  wb_data, 0);
    step();
    chk("rw.wb_valid2", 32'(wb_valid), 0);
    chk("rw.mem_req2b", 32'(mem_req), 0);
    do_alu(4'd1, 32'h0000_0009, 5'd12);
    step();
    chk("pulse.wb_valid", 32'(wb_valid), 0);
    chk("pulse.err",      32'(err), 0);

    // Randomized mix; back-to-back ALU ops keep in_valid high across edges.
    for (int unsigned i = 0; i < 80; i++) begin
      r = $urandom;
      if (r[1:0] == 2'b00) begin
        op = r[2] ? 4'hC : 4'hB;
        r = $urandom;
        if (r[3:0] == 4'd0) r[1:0] = 2'($urandom_range(1, 3));
        else                r[1:0] = 2'b00;
        do_mem(op, r, $urandom, 5'($urandom), $urandom_range(1, TMO + 2), $urandom);
      end else begin
        op = 4'($urandom);
        if (op == 4'hB || op == 4'hC) op = 4'd2;
        do_alu(op, $urandom, 5'($urandom));
      end
    end
    step();
    chk("end.wb_valid", 32'(wb_valid), 0);
    chk("end.err",      32'(err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage_32.md
MEM_STAGE_32 -- requirements
Module: mem_stage_32

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max cycles mem_req held without mem_ack before abort (range 1..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  execute-stage result present.
REQ-005 SHALL have port in_ready  output  1  stage can accept; transfer when in_valid && in_ready at clk edge.
REQ-006 SHALL have port in_op  input  4  lower four opcode bits (ADD=1..SRL=9, LD=B, ST=C).
REQ-007 SHALL have port in_res  input  32  ALU result; the memory address for LD/ST.
REQ-008 SHALL have port in_st_data  input  32  store data for ST.
REQ-009 SHALL have port in_rd  input  5  destination register index.
REQ-010 SHALL have ports mem_req output 1, mem_we output 1, mem_addr output 32, mem_wdata output 32: data-memory request bundle.
REQ-011 SHALL have ports mem_rdata input 32, mem_ack input 1: memory response; ack completes the request.
REQ-012 SHALL have ports wb_valid output 1, wb_we output 1, wb_rd output 5, wb_data output 32: writeback bundle.
REQ-013 SHALL have port err  output  1  one-cycle pulse on misaligned access or timeout.

Function
REQ-014 SHALL implement FSM states IDLE, MEM_WAIT; in_ready = 1 only in IDLE.
REQ-015 SHALL, on accept in IDLE of op 1..9: next cycle wb_valid=1, wb_data=in_res, wb_rd=in_rd, wb_we=(in_rd!=0); remain IDLE.
REQ-016 SHALL, on accept of op 0, A, D, E, F: next cycle wb_valid=1, wb_we=0, wb_data=in_res; no memory access.
REQ-017 SHALL, on accept of LD/ST with in_res[1:0]!=0: no memory access; next cycle wb_valid=1, wb_we=0, err=1; remain IDLE.
REQ-018 SHALL, on accept of aligned LD/ST: next cycle mem_req=1, mem_addr=in_res, mem_we=(op==ST), mem_wdata=in_st_data (0 for LD); enter MEM_WAIT; clear timeout counter.
REQ-019 SHALL hold mem_req, mem_we, mem_addr, mem_wdata stable throughout MEM_WAIT until ack or abort.
REQ-020 SHALL, on mem_ack=1 sampled in MEM_WAIT: next cycle mem_req=0, state IDLE, wb_valid=1, wb_rd=latched rd; LD: wb_data=mem_rdata sampled that edge, wb_we=(rd!=0); ST: wb_data=address, wb_we=0.
REQ-021 SHALL ignore mem_ack while mem_req=0.
REQ-022 SHALL increment timeout counter each MEM_WAIT cycle without ack; on reaching TIMEOUT: next cycle mem_req=0, IDLE, wb_valid=1, wb_we=0, err=1.
REQ-023 SHALL give mem_ack priority over timeout when both occur on the same edge.
REQ-024 SHALL drive wb_valid and err as single-cycle pulses; wb_data/wb_rd hold last value otherwise.
REQ-025 SHALL drive all outputs from registers (no combinational path input to output) except in_ready, decoded from state.
REQ-026 SHALL sustain one non-memory accept per cycle (back-to-back wb_valid).

Reset
REQ-027 SHALL, while rst=1 at an edge: state=IDLE, counter=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, err=0.
REQ-028 SHALL, on rst during MEM_WAIT, drop mem_req next edge and discard the pending LD/ST without wb_valid.
REQ-029 SHALL treat in_valid during rst as not accepted.

Verification
REQ-030 SHALL cover: ADD in_res=0x00000007 in_rd=3 -> next cycle wb_valid=1 wb_we=1 wb_rd=3 wb_data=0x7, in_ready stays 1.
REQ-031 SHALL cover: LD in_res=0x00001000 in_rd=5, ack 3 cycles later with rdata=0xDEADBEEF -> mem_req high 3 cycles, in_ready=0, then wb_data=0xDEADBEEF wb_we=1.
REQ-032 SHALL cover: ST in_res=0x20 in_st_data=0x55 with ack same cycle as mem_req rise -> mem_we=1 wdata=0x55, wb_valid next cycle wb_we=0.
REQ-033 SHALL cover: LD in_res=0x00000002 -> no mem_req, err=1 and wb_valid=1 wb_we=0 next cycle.
REQ-034 SHALL cover: TIMEOUT=4, ST never acked -> mem_req exactly 4 cycles, then err=1, wb_valid=1, in_ready=1.
REQ-035 SHALL cover: rst asserted during MEM_WAIT -> mem_req=0 next edge, no wb_valid, next ADD accepted normally.
